// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM encodings,
// the MEM/WB bundle type and the alignment helper.
package mem_stage_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
    } memwb_t;

    // Size code 11 is handled exactly like a word.
    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [1:0] lane);
        logic ok;
        ok = 1'b1;
        unique case (1'b1)
            (size == SZ_BYTE): ok = 1'b1;
            (size == SZ_HALF): ok = ~lane[0];
            default:           ok = (lane == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: store steering and byte enables, load
// extraction with sign extension, and misalignment detection.
// Ports: st_* store side (current EX/MEM), ld_* load side (held access).
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] ld_ext,
    output logic        misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign misaligned = ~is_aligned(st_size, st_lane);

    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b1111;
        unique case (1'b1)
            (st_size == SZ_BYTE): begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_lane;
            end
            (st_size == SZ_HALF): begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = st_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[7:0];
        unique case (ld_lane)
            2'b00:   ld_byte = ld_rdata[7:0];
            2'b01:   ld_byte = ld_rdata[15:8];
            2'b10:   ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
    end

    assign ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    always_comb begin
        ld_ext = ld_rdata;
        unique case (1'b1)
            (ld_size == SZ_BYTE): ld_ext = {{24{ld_byte[7]}}, ld_byte};
            (ld_size == SZ_HALF): ld_ext = {{16{ld_half[15]}}, ld_half};
            default:              ld_ext = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: sized loads/stores over a req/ack bus, branch/JR redirect,
// pipeline stall while an access is outstanding, and the MEM/WB register.
// Ports: EX/MEM inputs (*_in), data bus (mem_*), stall/redirect, MEM/WB outs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk_in,
    input  logic              Rst,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              Branch_in,
    input  logic              Zero_in,
    input  logic              JR_in,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic [31:0]       ALUAddResult_in,
    input  logic [31:0]       ALUResult_in,
    input  logic [DATA_W-1:0] ReadData2_in,
    input  logic [4:0]        WriteReg_in,
    input  logic [1:0]        size_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic              PCSrc_out,
    output logic [31:0]       BranchTarget_out,
    output logic              align_err_out,
    output logic              RegWrite_out_MEMWB,
    output logic              MemtoReg_out_MEMWB,
    output logic [31:0]       ReadData_out_MEMWB,
    output logic [31:0]       ALUResult_out_MEMWB,
    output logic [4:0]        WriteReg_out_MEMWB
);

    logic [1:0]  state;
    logic        access;
    logic        misaligned;
    logic        in_idle;
    logic        in_req;
    logic        in_done;
    logic        go;
    logic        mis_now;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_ext;

    // Access captured when the request is launched.
    logic        h_read;
    logic        h_rw;
    logic        h_m2r;
    logic [31:0] h_alu;
    logic [4:0]  h_wr;
    logic [1:0]  h_size;
    logic [1:0]  h_lane;
    logic [31:0] cap_data;

    memwb_t      wb_next;
    memwb_t      wb_q;

    assign access  = MemRead_in | MemWrite_in;
    assign in_idle = (state == ST_IDLE);
    assign in_req  = (state == ST_REQ);
    assign in_done = (state == ST_DONE);
    assign go      = in_idle & access & ~misaligned;
    assign mis_now = in_idle & access & misaligned;

    assign stall_out = go | in_req;

    assign PCSrc_out = ((Branch_in & Zero_in) | JR_in) & ~stall_out;
    assign BranchTarget_out = JR_in ? ALUResult_in : ALUAddResult_in;

    mem_stage_align u_align (
        .st_size    (size_in),
        .st_lane    (ALUResult_in[1:0]),
        .st_data    (ReadData2_in),
        .ld_size    (h_size),
        .ld_lane    (h_lane),
        .ld_rdata   (mem_rdata),
        .st_wdata   (st_wdata),
        .st_be      (st_be),
        .ld_ext     (ld_ext),
        .misaligned (misaligned)
    );

    // Stall and misalignment both retire a bubble; DONE retires the access.
    always_comb begin
        wb_next = '0;
        unique case (1'b1)
            stall_out: wb_next = '0;
            mis_now:   wb_next = '0;
            in_done: begin
                wb_next.reg_write  = h_rw;
                wb_next.mem_to_reg = h_m2r;
                wb_next.read_data  = cap_data;
                wb_next.alu_result = h_alu;
                wb_next.write_reg  = h_wr;
            end
            default: begin
                wb_next.reg_write  = RegWrite_in;
                wb_next.mem_to_reg = MemtoReg_in;
                wb_next.read_data  = 32'd0;
                wb_next.alu_result = ALUResult_in;
                wb_next.write_reg  = WriteReg_in;
            end
        endcase
    end

    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            state         <= ST_IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= 4'b0000;
            h_read        <= 1'b0;
            h_rw          <= 1'b0;
            h_m2r         <= 1'b0;
            h_alu         <= 32'd0;
            h_wr          <= 5'd0;
            h_size        <= 2'b00;
            h_lane        <= 2'b00;
            cap_data      <= 32'd0;
            align_err_out <= 1'b0;
            wb_q          <= '0;
        end else begin
            align_err_out <= mis_now;
            wb_q          <= wb_next;
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        state     <= ST_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_in;
                        mem_addr  <= {ALUResult_in[ADDR_W-1:2], 2'b00};
                        mem_wdata <= st_wdata;
                        mem_be    <= st_be;
                        h_read    <= MemRead_in;
                        h_rw      <= RegWrite_in;
                        h_m2r     <= MemtoReg_in;
                        h_alu     <= ALUResult_in;
                        h_wr      <= WriteReg_in;
                        h_size    <= size_in;
                        h_lane    <= ALUResult_in[1:0];
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state    <= ST_DONE;
                        mem_req  <= 1'b0;
                        cap_data <= h_read ? ld_ext : 32'd0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign RegWrite_out_MEMWB  = wb_q.reg_write;
    assign MemtoReg_out_MEMWB  = wb_q.mem_to_reg;
    assign ReadData_out_MEMWB  = wb_q.read_data;
    assign ALUResult_out_MEMWB = wb_q.alu_result;
    assign WriteReg_out_MEMWB  = wb_q.write_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboarded MEM/WB results, bus lane
// checks, misalignment, redirect and reset-during-access.
module tb_mem_stage;

    logic        Clk_in = 1'b0;
    logic        Rst = 1'b1;
    logic        MemWrite_in, MemRead_in, Branch_in, Zero_in, JR_in;
    logic        MemtoReg_in, RegWrite_in;
    logic [31:0] ALUAddResult_in, ALUResult_in, ReadData2_in;
    logic [4:0]  WriteReg_in;
    logic [1:0]  size_in;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_out, PCSrc_out, align_err_out;
    logic [31:0] BranchTarget_out;
    logic        RegWrite_out_MEMWB, MemtoReg_out_MEMWB;
    logic [31:0] ReadData_out_MEMWB, ALUResult_out_MEMWB;
    logic [4:0]  WriteReg_out_MEMWB;

    mem_stage dut (
        .Clk_in(Clk_in), .Rst(Rst),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .Branch_in(Branch_in), .Zero_in(Zero_in), .JR_in(JR_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .ALUAddResult_in(ALUAddResult_in), .ALUResult_in(ALUResult_in),
        .ReadData2_in(ReadData2_in), .WriteReg_in(WriteReg_in),
        .size_in(size_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_out(stall_out), .PCSrc_out(PCSrc_out),
        .BranchTarget_out(BranchTarget_out),
        .align_err_out(align_err_out),
        .RegWrite_out_MEMWB(RegWrite_out_MEMWB),
        .MemtoReg_out_MEMWB(MemtoReg_out_MEMWB),
        .ReadData_out_MEMWB(ReadData_out_MEMWB),
        .ALUResult_out_MEMWB(ALUResult_out_MEMWB),
        .WriteReg_out_MEMWB(WriteReg_out_MEMWB)
    );

    always #5 Clk_in = ~Clk_in;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        bit          chk_rd;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_in();
        MemWrite_in = 0; MemRead_in = 0; Branch_in = 0; Zero_in = 0;
        JR_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
        ALUAddResult_in = 0; ALUResult_in = 0; ReadData2_in = 0;
        WriteReg_in = 0; size_in = 2'b00;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic m2r,
                         input logic rw, input logic [1:0] sz,
                         input logic [31:0] alu, input logic [31:0] d2,
                         input logic [4:0] wr);
        @(posedge Clk_in); #1;
        clear_in();
        MemRead_in = mr; MemWrite_in = mw; MemtoReg_in = m2r;
        RegWrite_in = rw; size_in = sz; ALUResult_in = alu;
        ReadData2_in = d2; WriteReg_in = wr;
    endtask

    task automatic push(input logic rw, input logic m2r, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [4:0] wr,
                        input bit chk_rd);
        exp_t e;
        e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.wr = wr;
        e.chk_rd = chk_rd;
        sb.push_back(e);
    endtask

    // Runs from IDLE to DONE; ack comes after ack_after idle REQ cycles.
    task automatic access(input int ack_after, input logic [31:0] rd,
                          output int stalls, output logic pc0,
                          output logic [31:0] f_addr, output logic [3:0] f_be,
                          output logic [31:0] f_wd, output logic f_we);
        int reqs = 0;
        bit done = 0;
        stalls = 0; pc0 = 1'b0; f_addr = 0; f_be = 0; f_wd = 0; f_we = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge Clk_in);
            if (c == 0) pc0 = PCSrc_out;
            mem_ack = 1'b0;
            if (!stall_out) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_req) begin
                    reqs++;
                    if (reqs == 1) begin
                        f_addr = mem_addr; f_be = mem_be;
                        f_wd = mem_wdata; f_we = mem_we;
                    end
                    if (reqs == ack_after + 1) begin
                        mem_ack = 1'b1;
                        mem_rdata = rd;
                    end
                end
            end
        end
        mem_ack = 1'b0;
        check("access_done_in_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic retire(input string tag);
        exp_t e;
        @(posedge Clk_in); #1;
        clear_in();
        @(negedge Clk_in);
        check({tag, "_sb_has_entry"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_regwrite"}, {31'd0, RegWrite_out_MEMWB}, {31'd0, e.rw});
            check({tag, "_memtoreg"}, {31'd0, MemtoReg_out_MEMWB}, {31'd0, e.m2r});
            check({tag, "_alu"}, ALUResult_out_MEMWB, e.alu);
            check({tag, "_wreg"}, {27'd0, WriteReg_out_MEMWB}, {27'd0, e.wr});
            if (e.chk_rd) check({tag, "_rdata"}, ReadData_out_MEMWB, e.rd);
        end
    endtask

    initial begin
        int st;
        logic pc0, we;
        logic [31:0] ad, wd;
        logic [3:0] be;
        bit seen;

        clear_in();
        mem_ack = 0;
        mem_rdata = 0;
        #12;
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_stall", {31'd0, stall_out}, 0);
        check("rst_align_err", {31'd0, align_err_out}, 0);
        check("rst_wb_rw", {31'd0, RegWrite_out_MEMWB}, 0);
        check("rst_wb_alu", ALUResult_out_MEMWB, 0);
        check("rst_mem_be", {28'd0, mem_be}, 0);
        @(negedge Clk_in);
        Rst = 0;

        // lw 0x10, ack on the third REQ cycle; branch must be masked.
        drive(1, 0, 1, 1, 2'b00, 32'h10, 0, 5'd5);
        Branch_in = 1; Zero_in = 1; ALUAddResult_in = 32'h40;
        push(1, 1, 32'hDEADBEEF, 32'h10, 5'd5, 1);
        access(2, 32'hDEADBEEF, st, pc0, ad, be, wd, we);
        check("lw_stall_cycles", st, 4);
        check("lw_pcsrc_masked", {31'd0, pc0}, 0);
        check("lw_addr", ad, 32'h10);
        check("lw_we", {31'd0, we}, 0);
        check("lw_be", {28'd0, be}, 32'hF);
        retire("lw");

        // sb 0x13
        drive(0, 1, 0, 0, 2'b10, 32'h13, 32'hA5, 5'd0);
        push(0, 0, 0, 32'h13, 5'd0, 0);
        access(0, 32'h0, st, pc0, ad, be, wd, we);
        check("sb_stall_cycles", st, 2);
        check("sb_be", {28'd0, be}, 32'b1000);
        check("sb_wdata", wd, 32'hA5A5A5A5);
        check("sb_we", {31'd0, we}, 1);
        check("sb_addr", ad, 32'h10);
        retire("sb");

        // lh 0x22 and lb 0x21
        drive(1, 0, 1, 1, 2'b01, 32'h22, 0, 5'd6);
        push(1, 1, 32'hFFFF8001, 32'h22, 5'd6, 1);
        access(0, 32'h80011234, st, pc0, ad, be, wd, we);
        check("lh_addr", ad, 32'h20);
        retire("lh");
        drive(1, 0, 1, 1, 2'b10, 32'h21, 0, 5'd7);
        push(1, 1, 32'h00000012, 32'h21, 5'd7, 1);
        access(1, 32'h80011234, st, pc0, ad, be, wd, we);
        check("lb_stall_cycles", st, 3);
        retire("lb");

        // misaligned lw 0x06
        drive(1, 0, 1, 1, 2'b00, 32'h06, 0, 5'd8);
        @(negedge Clk_in);
        check("mis_stall", {31'd0, stall_out}, 0);
        check("mis_req", {31'd0, mem_req}, 0);
        @(posedge Clk_in); #1;
        clear_in();
        @(negedge Clk_in);
        check("mis_align_err", {31'd0, align_err_out}, 1);
        check("mis_wb_rw", {31'd0, RegWrite_out_MEMWB}, 0);
        check("mis_req_after", {31'd0, mem_req}, 0);
        @(negedge Clk_in);
        check("mis_align_err_pulse", {31'd0, align_err_out}, 0);

        // redirect and pass-through
        @(posedge Clk_in); #1;
        clear_in();
        Branch_in = 1; Zero_in = 1; ALUAddResult_in = 32'h40;
        @(negedge Clk_in);
        check("beq_pcsrc", {31'd0, PCSrc_out}, 1);
        check("beq_target", BranchTarget_out, 32'h40);
        Zero_in = 0;
        #1;
        check("bne_pcsrc", {31'd0, PCSrc_out}, 0);
        Branch_in = 0; JR_in = 1; ALUResult_in = 32'h100;
        #1;
        check("jr_pcsrc", {31'd0, PCSrc_out}, 1);
        check("jr_target", BranchTarget_out, 32'h100);
        drive(0, 0, 0, 1, 2'b00, 32'h55, 0, 5'd9);
        push(1, 0, 0, 32'h55, 5'd9, 1);
        retire("alu");

        // reset in the middle of an access, then a stray ack
        drive(1, 0, 1, 1, 2'b00, 32'h20, 0, 5'd3);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clk_in);
            if (mem_req) seen = 1;
        end
        check("rst_seq_req_seen", {31'd0, seen}, 1);
        #1;
        Rst = 1;
        clear_in();
        #1;
        check("midrst_req", {31'd0, mem_req}, 0);
        check("midrst_stall", {31'd0, stall_out}, 0);
        check("midrst_be", {28'd0, mem_be}, 0);
        check("midrst_wb_rw", {31'd0, RegWrite_out_MEMWB}, 0);
        @(negedge Clk_in);
        Rst = 0;
        @(posedge Clk_in); #1;
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        @(posedge Clk_in); #1;
        mem_ack = 0;
        @(negedge Clk_in);
        check("stray_req", {31'd0, mem_req}, 0);
        check("stray_stall", {31'd0, stall_out}, 0);
        check("stray_wb_rw", {31'd0, RegWrite_out_MEMWB}, 0);
        check("stray_wb_rdata", ReadData_out_MEMWB, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
